// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin, packet-granular arbiter sharing one UART TX byte port among
// NREQ byte-stream producers. The owner of the channel streams straight
// through with no buffering. An idle timeout reclaims the channel from an
// owner that stops presenting bytes mid-packet.

// One requester's slice of the TX path: qualifies valid/ready with the
// lane select and zeroes data when nothing is offered.
module uart_tx_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_data,
    input  logic              tx_ready,
    output logic              req_ready,
    output logic              lane_valid,
    output logic [DATA_W-1:0] lane_data
);

    // Pass-through when selected; zero otherwise so lanes can be OR-merged.
    always_comb begin
        req_ready  = sel & tx_ready;
        lane_valid = sel & req_valid;
        lane_data  = lane_valid ? req_data : '0;
    end

endmodule

module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_valid,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_ready,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout_pulse
);

    localparam int GID_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                       state;
    logic [GID_W-1:0]             last_ptr;
    logic [CNT_W-1:0]             idle_cnt;

    logic                         arb_found;
    logic [GID_W-1:0]             arb_idx;
    logic [GID_W-1:0]             cand;

    logic [NREQ-1:0]              lane_sel;
    logic [NREQ-1:0]              lane_valid;
    logic [NREQ-1:0][DATA_W-1:0]  lane_data;

    logic                         own_valid;
    logic                         own_last;

    assign own_valid = req_valid[grant_id];
    assign own_last  = req_last[grant_id];

    // Round-robin pick: first asserted request after the last owner, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GID_W'((int'(last_ptr) + k) % NREQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Per-requester pass-through slices; only the owner's slice is live in LOCK.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane_sel[i] = (state == LOCK) && (grant_id == GID_W'(i));

        uart_tx_arbiter_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .sel        (lane_sel[i]),
            .req_valid  (req_valid[i]),
            .req_data   (req_data[i*DATA_W +: DATA_W]),
            .tx_ready   (tx_ready),
            .req_ready  (req_ready[i]),
            .lane_valid (lane_valid[i]),
            .lane_data  (lane_data[i])
        );
    end

    // Merge lanes: at most one is non-zero, so OR is a mux.
    always_comb begin
        tx_valid = |lane_valid;
        tx_data  = '0;
        for (int j = 0; j < NREQ; j++) begin
            tx_data = tx_data | lane_data[j];
        end
    end

    // Ownership FSM: one arbitration cycle in IDLE, hold LOCK until the
    // owner's last byte is accepted or it stays silent for TIMEOUT cycles.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            last_ptr      <= GID_W'(NREQ - 1);
            grant_id      <= '0;
            idle_cnt      <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_id <= arb_idx;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (own_valid) begin
                        // A byte on offer, even under back-pressure, is activity.
                        idle_cnt <= '0;
                        if (tx_ready && own_last) begin
                            last_ptr <= grant_id;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                        last_ptr      <= grant_id;
                        idle_cnt      <= '0;
                        busy          <= 1'b0;
                        timeout_pulse <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a random phase. A
// reference model predicts per-cycle outputs and TX/timeout events into
// queues; an independent negedge monitor pops and compares.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 255;

    logic                   clk = 1'b0;
    logic                   nReset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_last = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   tx_valid;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_ready = 1'b0;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   timeout_pulse;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .nReset        (nReset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic l; } byte_t;
    typedef struct { int kind; int cyc; int g; int data; } ev_t;
    typedef struct { int cyc; int busy; int gid; int txv; int txd; int rdy; } cyc_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    byte_t pq[NREQ][$];
    bit [NREQ-1:0] vld = '0;
    bit [NREQ-1:0] stall = '0;
    bit eager = 1'b1;
    int tr_mode = 1;

    int m_owner = -1;
    int m_ptr   = NREQ - 1;
    int m_idle  = 0;
    int acc_cnt[NREQ];

    ev_t  ev_q[$];
    cyc_t cyc_q[$];

    int obs_d[$];
    int obs_c[$];
    int pkt_gid[$];
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int pushed = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(int i, int n, logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            byte_t b;
            b.d = base + 8'(k);
            b.l = (k == n - 1);
            pq[i].push_back(b);
            pushed++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (!vld[i] && pq[i].size() > 0 && !stall[i] && (eager || $urandom_range(0, 1) == 1))
                vld[i] = 1'b1;
            req_valid[i] = vld[i];
            if (vld[i]) begin
                req_data[i*DATA_W +: DATA_W] = pq[i][0].d;
                req_last[i] = pq[i][0].l;
            end else begin
                req_data[i*DATA_W +: DATA_W] = 8'($urandom);
                req_last[i] = 1'($urandom_range(0, 1));
            end
        end
        if (tr_mode == 1)      tx_ready = 1'b1;
        else if (tr_mode == 2) tx_ready = 1'b0;
        else                   tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference: who owns the channel, what it shows this cycle, and what
    // changes at the coming edge.
    task automatic model();
        cyc_t c;
        c.cyc  = cyc;
        c.busy = (m_owner >= 0);
        c.gid  = (m_owner >= 0) ? m_owner : 0;
        c.txv  = 0;
        c.txd  = 0;
        c.rdy  = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (req_valid[j]) begin
                    m_owner = j;
                    m_idle  = 0;
                    break;
                end
            end
        end else begin
            int g;
            g = m_owner;
            c.txv = req_valid[g];
            c.txd = req_valid[g] ? int'(req_data[g*DATA_W +: DATA_W]) : 0;
            c.rdy = tx_ready ? (1 << g) : 0;
            if (req_valid[g]) begin
                m_idle = 0;
                if (tx_ready) begin
                    ev_t e;
                    e.kind = 0; e.cyc = cyc; e.g = g; e.data = c.txd;
                    ev_q.push_back(e);
                    void'(pq[g].pop_front());
                    vld[g] = 1'b0;
                    acc_cnt[g]++;
                    if (req_last[g]) begin
                        m_owner = -1;
                        m_ptr   = g;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    ev_t e;
                    e.kind = 1; e.cyc = cyc + 1; e.g = g; e.data = 0;
                    ev_q.push_back(e);
                    m_owner = -1;
                    m_ptr   = g;
                    m_idle  = 0;
                end
            end
        end
        cyc_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1 drive();
        #1 model();
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_c.delete(); pkt_gid.delete();
        pulse_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 nReset = 1'b0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_timeout", timeout_pulse, 0);
        check("rst_grant", grant_id, 0);
        ev_q.delete(); cyc_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            pq[i].delete();
            acc_cnt[i] = 0;
        end
        vld = '0; stall = '0; req_valid = '0;
        m_owner = -1; m_ptr = NREQ - 1; m_idle = 0;
        clear_obs();
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;
    endtask

    task automatic drain(int maxc);
        int n;
        n = 0;
        while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() > 0 || m_owner >= 0) && n < maxc) begin
            step();
            n++;
        end
        check("drain_in_budget", n < maxc, 1);
        repeat (3) step();
        @(negedge clk);
        #1 check("ev_q_empty", ev_q.size(), 0);
    endtask

    // Monitor: compare per-cycle outputs and pop events when the DUT shows them.
    always @(negedge clk) begin
        if (nReset) begin
            if (cyc_q.size() > 0) begin
                cyc_t c;
                c = cyc_q.pop_front();
                check("cyc_stamp", cyc, c.cyc);
                check("busy", busy, c.busy);
                if (c.busy != 0) check("grant_id", grant_id, c.gid);
                check("tx_valid", tx_valid, c.txv);
                check("tx_data", tx_data, c.txd);
                check("req_ready", req_ready, c.rdy);
            end
            if (tx_valid && tx_ready) begin
                check("xfer_expected", ev_q.size() > 0, 1);
                if (ev_q.size() > 0) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("xfer_kind", e.kind, 0);
                    check("xfer_cyc", cyc, e.cyc);
                    check("xfer_gid", grant_id, e.g);
                    check("xfer_data", tx_data, e.data);
                end
                obs_d.push_back(int'(tx_data));
                obs_c.push_back(cyc);
                if (req_last[grant_id]) pkt_gid.push_back(int'(grant_id));
            end
            if (timeout_pulse) begin
                pulse_cnt++;
                pulse_cyc = cyc;
                check("pulse_expected", ev_q.size() > 0, 1);
                if (ev_q.size() > 0) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("pulse_kind", e.kind, 1);
                    check("pulse_cyc", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, n;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;

        // Reset state while inputs are active.
        req_valid = '1; tx_ready = 1'b1; req_data = 32'h41424344; req_last = '1;
        #1 nReset = 1'b0;
        #2;
        check("init_tx_valid", tx_valid, 0);
        check("init_tx_data", tx_data, 0);
        check("init_busy", busy, 0);
        check("init_req_ready", req_ready, 0);
        check("init_timeout", timeout_pulse, 0);
        check("init_grant", grant_id, 0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;

        // A: 3-byte packet from req 0 on consecutive cycles after one arb cycle.
        tr_mode = 1; eager = 1;
        c0 = cyc;
        push_pkt(0, 3, 8'h41);
        drain(50);
        check("a_nbytes", obs_d.size(), 3);
        for (int k = 0; k < 3 && k < obs_d.size(); k++) begin
            check("a_data", obs_d[k], 32'h41 + k);
            check("a_cyc", obs_c[k], c0 + 2 + k);
        end

        // B: all four contend with single-byte packets.
        do_reset();
        push_pkt(0, 1, 8'h10); push_pkt(1, 1, 8'h11); push_pkt(2, 1, 8'h12);
        push_pkt(3, 1, 8'h13); push_pkt(0, 1, 8'h14);
        drain(80);
        check("b_npkts", pkt_gid.size(), 5);
        for (int k = 0; k < 5 && k < pkt_gid.size(); k++) begin
            check("b_order", pkt_gid[k], k % NREQ);
            check("b_data", obs_d[k], 32'h10 + k);
            if (k > 0) check("b_gap", obs_c[k] - obs_c[k-1], 2);
        end

        // C: long back-pressure never times out.
        do_reset();
        push_pkt(2, 2, 8'hA0);
        tr_mode = 2;
        repeat (500) step();
        #1;
        check("c_no_pulse", pulse_cnt, 0);
        check("c_no_xfer", obs_d.size(), 0);
        check("c_busy", busy, 1);
        check("c_grant", grant_id, 2);
        tr_mode = 1;
        drain(50);
        check("c_nbytes", obs_d.size(), 2);

        // D: req 1 stalls mid-packet, times out, req 2 takes over.
        do_reset();
        push_pkt(1, 3, 8'hB0);
        n = 0;
        while (acc_cnt[1] < 1 && n < 20) begin step(); n++; end
        check("d_first_byte", acc_cnt[1], 1);
        stall[1] = 1'b1;
        push_pkt(2, 2, 8'hC0);
        n = 0;
        while (pulse_cnt == 0 && n < 400) begin step(); n++; end
        check("d_pulse_cnt", pulse_cnt, 1);
        if (obs_c.size() > 0) check("d_pulse_delay", pulse_cyc - obs_c[0], TIMEOUT + 1);
        n = 0;
        while (pkt_gid.size() == 0 && n < 20) begin step(); n++; end
        check("d_next_grant", pkt_gid.size() > 0 ? pkt_gid[0] : -1, 2);
        stall[1] = 1'b0;
        drain(50);
        check("d_npkts", pkt_gid.size(), 2);
        if (pkt_gid.size() == 2) check("d_resume_grant", pkt_gid[1], 1);
        check("d_nbytes", obs_d.size(), 5);
        if (obs_d.size() == 5) begin
            check("d_b0", obs_d[0], 32'hB0);
            check("d_c0", obs_d[1], 32'hC0);
            check("d_b1", obs_d[3], 32'hB1);
        end

        // E: req 0 and req 3 contend right after a req 3 packet.
        do_reset();
        push_pkt(3, 4, 8'hE0);
        step(); step();
        push_pkt(0, 1, 8'hD0);
        push_pkt(3, 1, 8'hF0);
        drain(60);
        check("e_npkts", pkt_gid.size(), 3);
        if (pkt_gid.size() == 3) begin
            check("e_first", pkt_gid[0], 3);
            check("e_second", pkt_gid[1], 0);
            check("e_third", pkt_gid[2], 3);
        end

        // F: reset mid-packet, then req 0 wins over req 3.
        do_reset();
        push_pkt(0, 5, 8'h50);
        repeat (3) step();
        #1;
        check("f_mid_busy", busy, 1);
        check("f_mid_txv", tx_valid, 1);
        do_reset();
        push_pkt(3, 1, 8'h63);
        push_pkt(0, 1, 8'h60);
        drain(40);
        check("f_nbytes", obs_d.size(), 2);
        if (pkt_gid.size() == 2) begin
            check("f_first", pkt_gid[0], 0);
            check("f_second", pkt_gid[1], 3);
        end

        // G: random traffic and back-pressure.
        do_reset();
        pushed = 0;
        eager = 1'b0;
        tr_mode = 0;
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                int r;
                r = $urandom_range(0, NREQ - 1);
                if (pq[r].size() < 8) push_pkt(r, $urandom_range(1, 4), 8'($urandom));
            end
            step();
        end
        drain(3000);
        check("g_all_bytes", obs_d.size(), pushed);
        check("g_no_pulse", pulse_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
